// File: rtl/alu_pkg.sv
// Shared constants and types for the 32-bit add/subtract unit.
// No logic; referenced by the adder and the top level.
// Operation encodings match the meaning of the sub input.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef logic [ALU_W-1:0] word_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_cla32.sv
// 32-bit two-level carry-lookahead adder with carry-into-MSB and carry-out.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module alu_cla32
    import alu_pkg::*;
(
    input  word_t x,
    input  word_t y,
    input  logic  cin,
    output word_t sum,
    output logic  c31,
    output logic  c32
);

    localparam int NGRP = ALU_W / 4;

    word_t             bp;
    word_t             bg;
    logic [NGRP-1:0]   gp;
    logic [NGRP-1:0]   gg;
    logic [NGRP:0]     gc;
    logic [ALU_W-1:0]  c;

    assign bp = x ^ y;
    assign bg = x & y;

    // Group propagate/generate for each 4-bit slice.
    always_comb begin
        gp = '0;
        gg = '0;
        for (int i = 0; i < NGRP; i++) begin
            gp[i] = bp[4*i+3] & bp[4*i+2] & bp[4*i+1] & bp[4*i];
            gg[i] = bg[4*i+3]
                  | (bp[4*i+3] & bg[4*i+2])
                  | (bp[4*i+3] & bp[4*i+2] & bg[4*i+1])
                  | (bp[4*i+3] & bp[4*i+2] & bp[4*i+1] & bg[4*i]);
        end
    end

    // Second-level lookahead: every group carry-in is a flat sum of products
    // of group generate/propagate terms and cin, not a ripple chain.
    always_comb begin
        logic acc;
        logic term;
        gc    = '0;
        gc[0] = cin;
        for (int j = 1; j <= NGRP; j++) begin
            acc = 1'b0;
            for (int k = 0; k < j; k++) begin
                term = gg[k];
                for (int m = k + 1; m < j; m++) term = term & gp[m];
                acc = acc | term;
            end
            term = cin;
            for (int m = 0; m < j; m++) term = term & gp[m];
            gc[j] = acc | term;
        end
    end

    // First-level lookahead: bit carries inside each group from its group carry-in.
    always_comb begin
        logic acc;
        logic term;
        c = '0;
        for (int i = 0; i < NGRP; i++) begin
            for (int k = 0; k < 4; k++) begin
                term = gc[i];
                for (int m = 0; m < k; m++) term = term & bp[4*i+m];
                acc = term;
                for (int n = 0; n < k; n++) begin
                    term = bg[4*i+n];
                    for (int m = n + 1; m < k; m++) term = term & bp[4*i+m];
                    acc = acc | term;
                end
                c[4*i+k] = acc;
            end
        end
    end

    assign sum = bp ^ c;
    assign c31 = c[ALU_W-1];
    assign c32 = gc[NGRP];

endmodule

// File: rtl/alu.sv
// 32-bit add/subtract with signed or unsigned overflow flag, registered output.
// Latency 1 cycle, one operation accepted every cycle.
// No backpressure; async active-high reset clears the outputs immediately.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  word_t a,
    input  word_t b,
    input  logic  sign,
    input  logic  sub,
    output word_t p,
    output logic  overflow
);

    word_t b_eff;
    word_t sum;
    logic  c31;
    logic  c32;
    logic  ov_next;

    // Subtract is a + ~b + 1, so the carry-in doubles as the "+1".
    assign b_eff = (sub == OP_SUB) ? ~b : b;

    alu_cla32 u_cla (
        .x   (a),
        .y   (b_eff),
        .cin (sub),
        .sum (sum),
        .c31 (c31),
        .c32 (c32)
    );

    // Signed overflow: carry into and out of the MSB disagree. Unsigned: carry
    // for add, missing carry (borrow) for subtract.
    always_comb begin
        ov_next = 1'b0;
        if (sign) begin
            ov_next = c31 ^ c32;
        end else if (sub == OP_SUB) begin
            ov_next = ~c32;
        end else begin
            ov_next = c32;
        end
    end

    // Output register; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p        <= '0;
            overflow <= 1'b0;
        end else begin
            p        <= sum;
            overflow <= ov_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, monitor compares.
// Reference model works on wide integers rather than carry bits.
module tb_alu;
    import alu_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    word_t a = '0;
    word_t b = '0;
    logic  sign = 1'b0;
    logic  sub = 1'b0;
    word_t p;
    logic  overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int n_res = 0;

    logic [32:0] expq [$];

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .sign     (sign),
        .sub      (sub),
        .p        (p),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Returns {overflow, p} from plain integer arithmetic.
    function automatic logic [32:0] model(input word_t x, input word_t y,
                                          input logic sg, input logic sb);
        longint r;
        logic   o;
        if (sg) begin
            r = sb ? longint'($signed(x)) - longint'($signed(y))
                   : longint'($signed(x)) + longint'($signed(y));
            o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end else begin
            r = sb ? longint'({32'b0, x}) - longint'({32'b0, y})
                   : longint'({32'b0, x}) + longint'({32'b0, y});
            o = (r < 0) || (r > 64'sd4294967295);
        end
        return {o, r[31:0]};
    endfunction

    task automatic drive(input word_t x, input word_t y, input logic sg, input logic sb);
        @(negedge clk);
        a    = x;
        b    = y;
        sign = sg;
        sub  = sb;
        expq.push_back(model(x, y, sg, sb));
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (p !== 32'h0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: p=%h ov=%b, required p=00000000 ov=0", name, p, overflow);
        end
    endtask

    // Monitor: each non-reset edge produces one result for the oldest pending vector.
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            if (!rst) begin
                #1;
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    n_cmp++;
                    n_res++;
                    if (p !== e[31:0] || overflow !== e[32]) begin
                        n_bad++;
                        $display("FAIL result #%0d: p=%h ov=%b, required p=%h ov=%b",
                                 n_res, p, overflow, e[31:0], e[32]);
                    end
                end
            end
        end
    end

    initial begin
        word_t edges [6];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF;
        edges[5] = 32'h8000_0001;

        // Reset with arbitrary inputs, checked between edges.
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; sign = 1'b1; sub = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check_zero("reset_hold");

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("pre_first_edge");

        // Directed vectors.
        drive(32'h0000_000A, 32'h0000_00A0, 1'b0, OP_ADD);
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
        drive(32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUB);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, OP_ADD);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
        drive(32'h8000_0000, 32'h0000_0001, 1'b1, OP_SUB);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, OP_SUB);
        drive(32'h1234_5678, 32'h1234_5678, 1'b0, OP_SUB);
        drive(32'h8000_0000, 32'h8000_0000, 1'b1, OP_ADD);
        drive(32'h0000_0000, 32'h8000_0000, 1'b1, OP_SUB);

        // Boundary-operand sweep across all four modes.
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                drive(edges[i], edges[j], 1'($urandom_range(0, 1)), 1'(j & 1));

        // Back-to-back random vectors.
        for (int i = 0; i < 60; i++)
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Mid-stream asynchronous reset between edges.
        drive($urandom, $urandom, 1'b1, OP_ADD);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        expq.delete();
        @(posedge clk);
        #3;
        check_zero("reset_held_edge");
        @(negedge clk);
        rst = 1'b0;
        a = 32'h7FFF_FFF0; b = 32'h0000_0020; sign = 1'b1; sub = OP_ADD;
        expq.push_back(model(a, b, sign, sub));
        #1;
        check_zero("post_reset_pre_edge");

        for (int i = 0; i < 100; i++)
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge clk);
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
